// File: rtl/fetch_queue_if.sv
// Fetch-queue port bundle between IF (master side) and the queue (slave side).
// The ID-facing head signals ride in the same bundle so one interface carries the whole handshake.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] PC_IF;
    logic [XLEN-1:0] INSTRUCTION_IF;
    logic            flush;
    logic            ID_ready;
    logic            PC_write;
    logic [XLEN-1:0] PC_ID;
    logic [XLEN-1:0] INSTRUCTION_ID;
    logic            valid_ID;
    logic [CW-1:0]   count;

    modport master (
        output PC_IF, INSTRUCTION_IF, flush, ID_ready,
        input  PC_write, PC_ID, INSTRUCTION_ID, valid_ID, count
    );

    modport slave (
        input  PC_IF, INSTRUCTION_IF, flush, ID_ready,
        output PC_write, PC_ID, INSTRUCTION_ID, valid_ID, count
    );
endinterface

// File: rtl/fetch_queue.sv
// IF->ID instruction fetch queue: circular buffer of {PC, instruction}, one-cycle flush.
// Optional same-cycle bypass on an empty queue is enabled with `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] NOP        = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;

    logic not_full;
    logic not_empty;
    logic push;
    logic wr_en;
    logic pop;
    logic head_valid;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_ins;

    // Handshake: an entry moves from IF into the queue on an edge where PC_write=1 and flush=0;
    // the head moves to ID on an edge where valid_ID=1, ID_ready=1 and flush=0. Flush wins over both.
    assign not_full  = (count_q != FULL_COUNT);
    assign not_empty = (count_q != '0);
    assign push      = not_full && !fq.flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // Bypass is gated by reset so outputs hold their reset values while reset is low.
    assign bypass = reset && !not_empty && push;
    assign wr_en  = push && !(bypass && fq.ID_ready);
`else
    assign wr_en  = push;
`endif

    // Only stored entries are popped; a bypassed entry never enters the pointers.
    assign pop = not_empty && fq.ID_ready && !fq.flush;

    always_comb begin
        count_next = count_q;
        if (fq.flush) begin
            count_next = '0;
        end else begin
            count_next = count_q + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_next;
            if (fq.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Storage contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]  <= fq.PC_IF;
            ins_mem[wr_ptr] <= fq.INSTRUCTION_IF;
        end
    end

    always_comb begin
        head_valid = not_empty;
        head_pc    = '0;
        head_ins   = NOP;
        if (not_empty) begin
            head_pc  = pc_mem[rd_ptr];
            head_ins = ins_mem[rd_ptr];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            head_valid = 1'b1;
            head_pc    = fq.PC_IF;
            head_ins   = fq.INSTRUCTION_IF;
        end
`endif
    end

    // PC_write is decoded from count_q alone, so IF sees no combinational path from ID or flush.
    assign fq.PC_write       = not_full;
    assign fq.valid_ID       = head_valid;
    assign fq.PC_ID          = head_pc;
    assign fq.INSTRUCTION_ID = head_ins;
    assign fq.count          = count_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF stage and the ID stage of the 5-stage RISC-V pipeline. It buffers up to DEPTH {PC, instruction} pairs produced by IF. It drives IF's PC_write so fetch stalls only when the queue is full, which decouples decode stalls from fetch. A taken branch (PCSrc) flushes every queued entry in one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- XLEN, 32, PC and instruction width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 clears the queue immediately
- PC_IF  in  XLEN  PC of the instruction currently presented by IF
- INSTRUCTION_IF  in  XLEN  instruction at PC_IF
- flush  in  1  connected to PCSrc; discards all entries and suppresses this cycle's push
- ID_ready  in  1  ID accepts the head entry this cycle
- PC_write  out  1  to IF; 1 = queue not full, so IF's PC advances and the IF entry is pushed
- PC_ID  out  XLEN  PC of head entry; 0 when empty
- INSTRUCTION_ID  out  XLEN  head instruction; 32'h00000013 (NOP) when empty
- valid_ID  out  1  head entry valid
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage is a circular buffer of DEPTH entries with read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH with no special case. A separate count register holds occupancy.
- PC_write = (count != DEPTH). It is decoded from registered state only and has no combinational path from any input.
- push = PC_write && !flush. On push, {PC_IF, INSTRUCTION_IF} is written at wr_ptr and wr_ptr increments.
- pop = valid_ID && ID_ready && !flush. On pop, rd_ptr increments.
- count_next = count + push - pop, except on flush.
- Flush has priority over push and pop:
  - rd_ptr, wr_ptr and count go to 0 on the next edge.
  - The head presented during the flush cycle counts as not consumed. ID must discard it because it is also flushed by PCSrc.
- Push and pop in the same cycle leave count unchanged. Push on full cannot occur because PC_write is 0 when full.
- valid_ID = (count != 0).
- Outputs when empty:
  - PC_ID is forced to 0.
  - INSTRUCTION_ID is forced to the NOP 32'h00000013.
- Reset state:
  - count = 0, so valid_ID = 0 and PC_write = 1.
  - Pointers = 0.
  - PC_ID = 0, INSTRUCTION_ID = 32'h00000013.
  - Storage contents are don't-care.
- Reset asserted mid-operation drops all entries asynchronously. The outputs take their reset values while reset is low.

## Timing
- Latency without bypass: an entry pushed at edge N is visible on the outputs after edge N, with valid_ID = 1 in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- PC_write falls in the cycle after the edge that makes count = DEPTH. It rises in the cycle after the first pop from full.
- After a flush edge, the queue is empty for at least one cycle unless bypass is enabled.
- ID_ready may change in any cycle. The head stays stable until it is popped or flushed.

## Configuration
- FETCH_QUEUE_BYPASS_EN is defined:
  - When count == 0 and push is 1, the IF entry is driven combinationally onto PC_ID and INSTRUCTION_ID, with valid_ID = 1.
  - If ID_ready is also 1, the entry is consumed without being written: pointers and count are unchanged.
  - If ID_ready is 0, the entry is written normally.
  - Fetch-to-decode latency on an empty queue is 0 cycles.
- FETCH_QUEUE_BYPASS_EN is undefined:
  - valid_ID depends only on count.
  - Outputs come purely from registers and the storage array.
  - Latency is always 1 cycle.

## Test plan
- Reset and idle: assert reset = 0 with PC_IF = 0x40. Require count = 0, valid_ID = 0, PC_write = 1, INSTRUCTION_ID = 0x00000013, PC_ID = 0.
- Fill and stall: hold ID_ready = 0 and present PCs 0x0, 0x4, 0x8, 0xC. Require count = 4 and PC_write = 0 after the 4th edge. Holding PC_IF = 0x10 for further cycles must not change count.
- Order and wrap: from full, pulse ID_ready = 1 for 6 cycles while IF continues from 0x10. Require PC_ID sequence 0x0, 0x4, 0x8, 0xC, 0x10, 0x14 with no gaps, and pointers wrapping.
- Flush priority: with count = 3, assert flush = 1 and ID_ready = 1 in the same cycle. Require count = 0 and valid_ID = 0 next cycle, PC_IF not pushed. The next push (PC_IF = 0x80) must appear as the head.
- Simultaneous push/pop: with count = 2, hold ID_ready = 1 for 10 cycles. Require count to stay at 2 and PC_ID to advance by 4 each cycle.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, ID_ready = 1, PC_IF = 0x200. Require valid_ID = 1 and PC_ID = 0x200 in the same cycle, with count staying 0. Without the macro, PC_ID = 0x200 appears one cycle later.
